// File: rtl/count_sched_pkg.sv
// Shared types, default sizes and the round-robin search used by count_scheduler.
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int MAX_REQ     = 8;
    localparam int IDX_W       = 3;

    typedef logic [IDX_W-1:0] idx_t;

    // First set request at or above ptr, wrapping at num; returns ptr when none is set.
    function automatic idx_t rr_next(input logic [MAX_REQ-1:0] reqs, input idx_t ptr, input int num);
        idx_t pick;
        logic found;
        int   j;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= num) begin
                j = j - num;
            end
            if (i < num && !found && reqs[j[IDX_W-1:0]]) begin
                pick  = idx_t'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sched_counter.sv
// Shared run counter: synchronous clear, enable, and a registered wrap pulse.
module sched_counter
    import count_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (enable) begin
                count <= count + WIDTH'(1);
            end
            // High in the cycle the count reads 0 after wrapping from all-ones.
            overflow <= enable && (count == {WIDTH{1'b1}});
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin owner of the shared run counter: grants one requester at a time,
// times its programmed run, and pulses that requester's done at the terminal count.
module count_scheduler
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         counter_out,
    output logic                     overflow_out,
    output logic                     busy
);

    state_t             state, state_next;
    idx_t               cur_idx, ptr, win, ptr_inc;
    logic [WIDTH-1:0]   cur_len, win_len;
    logic [MAX_REQ-1:0] req_pad;
    logic [NUM_REQ-1:0] win_oh, cur_oh;
    logic               any_req, cur_req, terminal, abort, finish;
    logic               cnt_clear, cnt_enable;

    always_comb begin
        req_pad = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_pad[i] = req[i];
        end
    end

    assign win = rr_next(req_pad, ptr, NUM_REQ);

    always_comb begin
        win_oh  = '0;
        cur_oh  = '0;
        win_len = '0;
        cur_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == idx_t'(i)) begin
                win_oh[i] = 1'b1;
                win_len   = len[i*WIDTH +: WIDTH];
            end
            if (cur_idx == idx_t'(i)) begin
                cur_oh[i] = 1'b1;
                cur_req   = req[i];
            end
        end
    end

    assign any_req = |req;
    assign ptr_inc = (cur_idx == idx_t'(NUM_REQ - 1)) ? '0 : cur_idx + idx_t'(1);
    // A length of 0 naturally means a full wrap: count+1 reaches 0 only from all-ones.
    assign terminal   = (counter_out + WIDTH'(1)) == cur_len;
    assign cnt_clear  = (state == IDLE) && any_req;
    assign cnt_enable = (state == RUN) && cur_req;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: if (any_req) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN: begin
                if (!cur_req) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (terminal) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cur_idx <= '0;
            cur_len <= '0;
            ptr     <= '0;
            gnt     <= '0;
            done    <= '0;
        end else begin
            state <= state_next;
            done  <= '0;
            if (cnt_clear) begin
                cur_idx <= win;
                cur_len <= win_len;
                gnt     <= win_oh;
            end
            // The pointer rotates past the current owner whether it finished or gave up.
            if (abort || finish) begin
                gnt <= '0;
                ptr <= ptr_inc;
            end
            if (finish) begin
                done <= cur_oh;
            end
        end
    end

    sched_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (counter_out),
        .overflow (overflow_out)
    );

endmodule
